// File: rtl/decimal_to_binary.sv
// Packed-BCD to binary converter.
// One digit is folded into a 32-bit accumulator per clock, most-significant
// digit first, using acc*10 = (acc<<3) + (acc<<1). A request whose BCD word
// holds a nibble above 9 skips conversion and reports err instead.
//
// Handshake: a request is taken on a rising edge where start && ready.
// ready = (state == IDLE) && !run_stop, so run_stop only refuses new work and
// never aborts a conversion already running. done is a one-cycle pulse with
// no backpressure; binout and err hold until the next completion/acceptance.
module decimal_to_binary #(
  parameter int NDIG = 6  // number of BCD digits, 1..8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] decimalin,
  input  logic              start,
  input  logic              run_stop,
  output logic              ready,
  output logic [31:0]       binout,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Counter value on the edge that consumes the final digit.
  localparam logic [3:0] LAST_CNT = 4'(NDIG - 1);

  state_t            state;
  state_t            state_next;
  logic [4*NDIG-1:0] shreg;
  logic [31:0]       acc;
  logic [31:0]       acc_next;
  logic [3:0]        cnt;
  logic [3:0]        cur_digit;
  logic              accept;
  logic              bad_digit;
  logic              last_digit;

  assign ready      = (state == IDLE) && !run_stop;
  assign accept     = start && ready;
  assign cur_digit  = shreg[4*NDIG-1 -: 4];
  assign last_digit = (cnt == LAST_CNT);
  assign acc_next   = (acc << 3) + (acc << 1) + {28'd0, cur_digit};

  // Flag any nibble of the incoming word that is not a decimal digit.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (decimalin[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> CONV/FAULT on acceptance, back to IDLE when done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bad_digit ? FAULT : CONV;
      CONV:    if (last_digit) state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch on acceptance, accumulate one digit per edge, report result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      binout <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= decimalin;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        CONV: begin
          acc   <= acc_next;
          shreg <= shreg << 4;
          cnt   <= cnt + 4'd1;
          if (last_digit) begin
            binout <= acc_next;
            done   <= 1'b1;
          end
        end
        FAULT: begin
          // binout deliberately untouched: the previous good result stays.
          err  <= 1'b1;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_to_binary.sv
// Self-checking bench for decimal_to_binary (NDIG = 6).
module tb_decimal_to_binary;

  localparam int NDIG = 6;
  localparam int W    = 4 * NDIG;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic          run_stop = 1'b0;
  logic [W-1:0]  decimalin = '0;
  logic          ready;
  logic [31:0]   binout;
  logic          done;
  logic          err;

  int            checks = 0;
  int            errors = 0;
  logic [32:0]   exp_q[$];           // {err, binout} expected per request
  logic [31:0]   model_bin = '0;
  logic          model_err = 1'b0;

  decimal_to_binary #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .decimalin (decimalin),
    .start     (start),
    .run_stop  (run_stop),
    .ready     (ready),
    .binout    (binout),
    .done      (done),
    .err       (err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Decimal value as the weighted sum of digits; invalid words keep prev.
  function automatic logic [32:0] ref_conv(input logic [W-1:0] bcd, input logic [31:0] prev);
    longint value;
    longint weight;
    int     d;
    bit     bad;
    value  = 0;
    weight = 1;
    bad    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      value  = value + longint'(d) * weight;
      weight = weight * 10;
    end
    if (bad) return {1'b1, prev};
    return {1'b0, value[31:0]};
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit valid);
    logic [W-1:0] b;
    int           pos;
    for (int i = 0; i < NDIG; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    if (!valid) begin
      pos = $urandom_range(0, NDIG - 1);
      b[4*pos +: 4] = 4'($urandom_range(10, 15));
    end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge (the acceptance edge N).
  task automatic drive_request(input logic [W-1:0] bcd);
    decimalin = bcd;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Edges after N until done is seen; -1 if it never comes.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (binout !== 32'd0) begin errors++; $display("FAIL reset_binout: got %h want 0", binout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    start = 1'b1;
    decimalin = 24'h123456;
    tick();
    tick();
    checks++; if (done !== 1'b0 || binout !== 32'd0) begin
      errors++; $display("FAIL reset_held: done %b binout %h want 0/0", done, binout);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ready); end
  endtask

  task automatic test_basic();
    int cycles;
    drive_request(24'h123456);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_n: got %b want 0", ready); end
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_busy: edge %0d got %b want 0", i, ready); end
    end
    checks++; if (cycles != NDIG) begin errors++; $display("FAIL basic_latency: got %0d want %0d", cycles, NDIG); end
    checks++; if (binout !== 32'h0001E240) begin errors++; $display("FAIL basic_binout: got %h want 0001e240", binout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
    checks++; if (binout !== 32'h0001E240) begin errors++; $display("FAIL basic_hold: got %h want 0001e240", binout); end
    model_bin = 32'h0001E240;
    model_err = 1'b0;
  endtask

  task automatic test_boundary();
    logic [W-1:0] vals[2];
    logic [31:0]  want[2];
    int           cycles;
    vals[0] = 24'h999999; want[0] = 32'h000F423F;
    vals[1] = 24'h000000; want[1] = 32'h00000000;
    for (int k = 0; k < 2; k++) begin
      drive_request(vals[k]);
      wait_done(cycles);
      checks++; if (cycles != NDIG) begin errors++; $display("FAIL bound_latency[%0d]: got %0d want %0d", k, cycles, NDIG); end
      checks++; if (binout !== want[k]) begin errors++; $display("FAIL bound_binout[%0d]: got %h want %h", k, binout, want[k]); end
      model_bin = want[k];
    end
  endtask

  task automatic test_random();
    logic [W-1:0] bcd;
    logic [32:0]  e;
    int           cycles;
    int           want_cycles;
    bit           valid;
    for (int n = 0; n < 24; n++) begin
      valid = ($urandom_range(0, 3) != 0);
      bcd   = rand_bcd(valid);
      e     = ref_conv(bcd, model_bin);
      exp_q.push_back(e);
      want_cycles = e[32] ? 1 : NDIG;
      drive_request(bcd);
      decimalin = W'($urandom);  // must not disturb the conversion in flight
      wait_done(cycles);
      e = exp_q.pop_front();
      checks++; if (cycles != want_cycles) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, cycles, want_cycles); end
      checks++; if ({err, binout} !== e) begin
        errors++; $display("FAIL rand_result[%0d] bcd %h: got err %b bin %h want err %b bin %h", n, bcd, err, binout, e[32], e[31:0]);
      end
      model_err = e[32];
      model_bin = e[31:0];
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_fault();
    int          cycles;
    logic [31:0] prev;
    // start from a known good result
    drive_request(24'h000321);
    wait_done(cycles);
    model_bin = 32'd321;
    prev = model_bin;
    drive_request(24'h12A456);
    wait_done(cycles);
    checks++; if (cycles != 1) begin errors++; $display("FAIL fault_latency: got %0d want 1", cycles); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_err: got %b want 1", err); end
    checks++; if (binout !== prev) begin errors++; $display("FAIL fault_binout: got %h want %h", binout, prev); end
    repeat (3) tick();
    checks++; if (err !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL fault_hold: err %b done %b want 1/0", err, done);
    end
    drive_request(24'h000042);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fault_err_clear: got %b want 0", err); end
    wait_done(cycles);
    checks++; if (binout !== 32'd42 || cycles != NDIG) begin
      errors++; $display("FAIL fault_recover: binout %h cycles %0d want 0000002a/%0d", binout, cycles, NDIG);
    end
    model_bin = 32'd42;
    model_err = 1'b0;
  endtask

  task automatic test_start_held();
    int dones;
    int cycles;
    dones  = 0;
    cycles = -1;
    decimalin = 24'h654321;
    start = 1'b1;
    tick();                 // edge N
    tick();                 // edge N+1
    decimalin = 24'h111111; // seen from edge N+2 on
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        dones++;
        cycles = i;
        break;
      end
    end
    start = 1'b0;           // dropped before edge N+7
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++; if (cycles != NDIG) begin errors++; $display("FAIL held_latency: got %0d want %0d", cycles, NDIG); end
    checks++; if (dones != 1) begin errors++; $display("FAIL held_done_count: got %0d want 1", dones); end
    checks++; if (binout !== 32'd654321) begin errors++; $display("FAIL held_binout: got %h want %h", binout, 32'd654321); end
    model_bin = 32'd654321;
  endtask

  task automatic test_run_stop();
    int dones;
    int cycles;
    dones = 0;
    run_stop  = 1'b1;
    start     = 1'b1;
    decimalin = 24'h777777;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL stop_ready: got %b want 0", ready); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    start    = 1'b0;
    run_stop = 1'b0;
    checks++; if (dones != 0) begin errors++; $display("FAIL stop_no_accept: done count %0d want 0", dones); end
    checks++; if (binout !== model_bin) begin errors++; $display("FAIL stop_binout: got %h want %h", binout, model_bin); end
    drive_request(24'h314159);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    run_stop = 1'b1;        // raised after edge N+3
    wait_done(cycles);
    checks++; if (dones != 0 || cycles != NDIG - 3) begin
      errors++; $display("FAIL stop_mid_latency: early %0d tail %0d want 0/%0d", dones, cycles, NDIG - 3);
    end
    checks++; if (binout !== 32'd314159) begin errors++; $display("FAIL stop_mid_binout: got %h want %h", binout, 32'd314159); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL stop_ready_idle: got %b want 0", ready); end
    run_stop = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL stop_ready_release: got %b want 1", ready); end
    model_bin = 32'd314159;
  endtask

  task automatic test_back_to_back();
    int dones;
    int cycles;
    dones = 0;
    drive_request(24'h000777);      // edge N
    for (int i = 1; i < NDIG; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    start = 1'b1;
    decimalin = 24'h888000;
    tick();                          // edge N+6: must not be sampled
    checks++; if (dones != 0 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done: early %0d done %b want 0/1", dones, done);
    end
    checks++; if (binout !== 32'd777) begin errors++; $display("FAIL b2b_first_binout: got %h want %h", binout, 32'd777); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_not_sampled: ready %b want 1", ready); end
    tick();                          // edge N+7: accepted
    start = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: ready %b want 0", ready); end
    wait_done(cycles);
    checks++; if (cycles != NDIG) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", cycles, NDIG); end
    checks++; if (binout !== 32'd888000) begin errors++; $display("FAIL b2b_binout: got %h want %h", binout, 32'd888000); end
    model_bin = 32'd888000;
  endtask

  task automatic test_reset_mid();
    int dones;
    int cycles;
    dones = 0;
    drive_request(24'h222222);       // edge N
    repeat (3) tick();               // through edge N+3
    rst_n = 1'b0;
    #1;
    checks++; if (binout !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear: binout %h done %b err %b want 0/0/0", binout, done, err);
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d want 0", dones); end
    checks++; if (binout !== 32'd0) begin errors++; $display("FAIL rst_mid_binout: got %h want 0", binout); end
    model_bin = 32'd0;
    model_err = 1'b0;
    drive_request(24'h000099);
    wait_done(cycles);
    checks++; if (cycles != NDIG || binout !== 32'd99 || err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_next: cycles %0d binout %h err %b want %0d/00000063/0", cycles, binout, err, NDIG);
    end
    model_bin = 32'd99;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_random();
    test_fault();
    test_start_held();
    test_run_stop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimal_to_binary.md
DECIMAL_TO_BINARY -- requirements
Module: decimal_to_binary

Interface
REQ-001 SHALL provide parameter NDIG, default 6, number of BCD digits converted; legal range 1..8.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port decimalin, input, 4*NDIG; packed BCD, most-significant digit in the top nibble.
REQ-005 SHALL provide port start, input, 1, conversion request, sampled on the rising edge.
REQ-006 SHALL provide port run_stop, input, 1; high = stop, new requests refused.
REQ-007 SHALL provide port ready, output, 1, high when a start will be accepted.
REQ-008 SHALL provide port binout, output, 32, registered binary result.
REQ-009 SHALL provide port done, output, 1, single-cycle completion pulse.
REQ-010 SHALL provide port err, output, 1, invalid-digit flag for the most recent request.

Function
REQ-011 SHALL implement states IDLE, CONV, FAULT.
REQ-012 SHALL accept a request at edge N only if state=IDLE, start=1 and run_stop=0; ready SHALL equal (state==IDLE && !run_stop).
REQ-013 On acceptance, SHALL latch decimalin into a digit shift register, clear the accumulator and digit counter, and clear err.
REQ-014 On acceptance, if any nibble of decimalin exceeds 9, SHALL go to FAULT instead of CONV.
REQ-015 In CONV, each edge SHALL compute acc <= acc*10 + current digit, MS digit first; multiply by 10 done as (acc<<3)+(acc<<1), no divider or multiplier.
REQ-016 SHALL process exactly NDIG digits: edges N+1..N+NDIG.
REQ-017 At edge N+NDIG, SHALL load binout with the final value, pulse done high for exactly one cycle, and return to IDLE.
REQ-018 Accumulator SHALL be 32 bits wide; for NDIG<=8 no overflow is possible (max 99,999,999).
REQ-019 From FAULT, at edge N+1 SHALL set err=1, pulse done for one cycle, leave binout unchanged, and return to IDLE.
REQ-020 err SHALL hold its value until the next accepted request.
REQ-021 start SHALL be ignored while state is CONV or FAULT; no queueing.
REQ-022 run_stop asserted during CONV SHALL NOT abort; the conversion completes and updates binout normally.
REQ-023 decimalin changes after acceptance SHALL NOT affect the result in progress.
REQ-024 binout SHALL hold its last value between conversions.
REQ-025 Back-to-back: a start at the edge where state returns to IDLE (edge N+NDIG) is not sampled; the earliest next acceptance is edge N+NDIG+1.

Reset
REQ-026 While rst_n=0, SHALL force state=IDLE, binout=0, done=0, err=0, accumulator/shift register/counter=0, independent of clk.
REQ-027 ready SHALL read 1 during reset when run_stop=0.
REQ-028 Reset asserted mid-conversion SHALL discard the conversion; no done pulse SHALL follow reset release.

Verification
REQ-029 NDIG=6, decimalin=0x123456, start at edge N -> binout=0x0001E240 (123456) and done=1 after edge N+6; ready low from N through N+5.
REQ-030 decimalin=0x999999 -> binout=0x000F423F (999999); decimalin=0x000000 -> binout=0, done pulses.
REQ-031 After a good result, decimalin=0x12A456 -> done and err=1 after edge N+1; binout keeps its previous value; err clears on the next valid request.
REQ-032 start held high throughout a conversion; decimalin changed at N+2 -> result reflects the value latched at N; exactly one done per acceptance.
REQ-033 run_stop=1 in IDLE with start=1 -> ready=0, no acceptance, binout unchanged; run_stop raised at N+3 -> conversion still completes at N+6.
REQ-034 rst_n pulsed low at N+3 -> binout=0, done=0, err=0 immediately; no done after release; next request converts correctly.
